osd_text_overlay: RTL and testbench
===================================

Name: osd_text_overlay

Overview:
- Parametrised text overlay generator for the OSD path; successor to the fixed 40x30 text-pattern block.
- Tracks beam position from hs_i/vs_i and holds a writable COLS x ROWS character/attribute RAM.
- Fetches glyph rows from an external font ROM and emits an RGB overlay pixel with a coverage flag.
- Adds per-character colour, blink and transparency, and full-rate rotation and scaling.

Parameters:
- COLS, 40: text columns.
- ROWS, 30: text rows.
- FONT_H, 16: glyph height in lines (8 or 16); glyphs are 8 pixels wide.
- BLINK_FRAMES, 32: frames per blink half-period.
- AW, clog2(COLS*ROWS): text RAM address width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_pix  in  1  pixel strobe; beam counters advance only when high.
- hs_i  in  1  horizontal sync, active low.
- vs_i  in  1  vertical sync, active low.
- enable  in  1  overlay enable.
- double_width  in  1  halve horizontal resolution (2x wide glyphs).
- double_height  in  1  halve vertical resolution.
- rotate  in  2  00 none, 01 clockwise, 10 counter-clockwise, 11 = none.
- adj_x  in  12  signed horizontal offset.
- adj_y  in  12  signed vertical offset.
- wr_en  in  1  text RAM write request.
- wr_addr  in  AW  cell index, row*COLS+col.
- wr_data  in  16  [7:0] char, [10:8] fg RGB, [13:11] bg RGB, [14] blink, [15] opaque bg.
- wr_ack  out  1  one-cycle pulse: write accepted.
- wr_err  out  1  one-cycle pulse: address out of range, write dropped.
- font_addr  out  8+clog2(FONT_H)  char*FONT_H + glyph line.
- font_data  in  8  glyph row; valid 1 clk after font_addr; bit 7 = leftmost pixel.
- pixel_out  out  3  RGB overlay pixel.
- pixel_valid  out  1  overlay covers this pixel.

Behaviour:
- Reset: beam counters, blink counter/phase, all pipeline registers, pixel_out, pixel_valid, wr_ack, wr_err, font_addr all 0. Text RAM contents are not reset.
- Beam counters: on ce_pix, cnt_x increments. A falling edge of hs_i (detected per clk) sets cnt_x=0 and either increments cnt_y, or clears it if vs_i=0.
- Edge detection: the hs_i edge takes priority over a ce_pix increment in the same clk.
- Blink: vs_i falling edge increments the frame counter. At BLINK_FRAMES-1 the counter wraps to 0 and blink phase toggles.
- Coordinates: x = cnt_x + adj_x, y = cnt_y + adj_y, signed 14-bit. A negative coordinate forces blank.
- Scaling: sx = x >> double_width, sy = y >> double_height.
- Mapping, rotate 00: col = sx/8, gx = sx%8, row = sy/FONT_H, gy = sy%FONT_H.
- Mapping, rotate 01: col = sy/8, gx = sy%8, row = ROWS-1 - sx/FONT_H, gy = FONT_H-1 - sx%FONT_H.
- Mapping, rotate 10: col = COLS-1 - sy/8, gx = 7 - sy%8, row = sx/FONT_H, gy = sx%FONT_H.
- Blank when enable=0, col>=COLS, row>=ROWS, or a negative index results.
- Pipeline (advances every clk, fixed latency 3 clk from beam-counter register to pixel_out):
  - stage 1: register RAM address, gx, gy, blank.
  - stage 2: RAM data available; register font_addr; delay attr, gx, blank.
  - stage 3: sample font_data; register pixel outputs.
- Pixel rule, in priority order:
  - blank: pixel_out=0, pixel_valid=0.
  - glyph bit = font_data[7-gx]; bit forced 0 when attr blink=1 and phase=1.
  - bit=1: pixel_out=fg, valid=1.
  - bit=0 and opaque=1: pixel_out=bg, valid=1.
  - otherwise: pixel_out=0, valid=0.
- Writes: accepted every clk with no backpressure. If wr_addr < COLS*ROWS, the RAM is written and wr_ack pulses next clk; otherwise nothing is written and wr_err pulses next clk.
- Read-during-write to the same cell returns old data (read-first).
- Reset mid-frame: pipeline flushes; output stays blank until the next hs_i falling edge re-establishes the counters.

Test Plan:
- Write 0x0741 to addr 0; font ROM model with char 0x41 line 0 = 0x80; rotate 00, adj 0, first ce_pix after hs edge on line 0 -> 3 clk later pixel_out=7, valid=1; next pixel valid=0.
- Same setup with attr 0x8741 (opaque, bg=0) -> second pixel pixel_out=0, valid=1; attr 0x8F41 -> second pixel pixel_out=1 (bg=001).
- wr_addr=1200 with COLS=40, ROWS=30 -> wr_err pulse, wr_ack=0, RAM unchanged; wr_addr=1199 -> wr_ack pulse.
- double_width=1: glyph pixel 0 spans beam x=0,1; adj_x=-4 -> first four ce_pix blank.
- rotate=01, char at row ROWS-1, col 0 -> drawn at beam x 0..FONT_H-1, y 0..7; font_addr line = FONT_H-1 at x=0.
- Blink attr set, BLINK_FRAMES=2: four vs_i frames -> glyph visible, visible, hidden, hidden; reset asserted mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/osd_text_overlay_if.sv
// osd_text_overlay_if: text RAM write port between a host (master) and the overlay (slave)
//   wr_en/wr_addr/wr_data : write request, cell index row*COLS+col, {opaque,blink,bg,fg,char}
//   wr_ack/wr_err         : one-cycle responses, accepted or dropped (address out of range)
interface osd_text_overlay_if #(parameter int AW = 11);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_ack;
  logic          wr_err;
  modport master (output wr_en, wr_addr, wr_data, input wr_ack, wr_err);
  modport slave (input wr_en, wr_addr, wr_data, output wr_ack, wr_err);
endinterface

// File: rtl/osd_text_overlay.sv
// osd_text_overlay: character-cell text overlay with colour, blink, transparency, rotation and scaling
//   clk, reset             : clock, asynchronous active-high reset
//   ce_pix, hs_i, vs_i     : pixel strobe, active-low syncs driving the beam counters
//   enable, double_width, double_height, rotate, adj_x, adj_y : display controls
//   wr                     : text RAM write port (osd_text_overlay_if.slave)
//   font_addr, font_data   : external font ROM, data sampled one clk after the address
//   pixel_out, pixel_valid : RGB overlay pixel and coverage flag, 3 clk after the beam counters
module osd_text_overlay #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int FONT_H = 16,
  parameter int BLINK_FRAMES = 32,
  parameter int AW = $clog2(COLS*ROWS),
  localparam int FW = $clog2(FONT_H)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce_pix,
  input  logic           hs_i,
  input  logic           vs_i,
  input  logic           enable,
  input  logic           double_width,
  input  logic           double_height,
  input  logic [1:0]     rotate,
  input  logic [11:0]    adj_x,
  input  logic [11:0]    adj_y,
  osd_text_overlay_if.slave wr,
  output logic [7+FW:0]  font_addr,
  input  logic [7:0]     font_data,
  output logic [2:0]     pixel_out,
  output logic           pixel_valid
);
  localparam int CELLS = COLS*ROWS;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic          hs_q, vs_q, hs_fall, vs_fall, blink_wrap;
  logic          line_ok_q, line_ok_d;
  logic [11:0]   cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [13:0]   x_c, y_c;
  logic [12:0]   sx, sy;
  logic [14:0]   col_c, row_c;
  logic [2:0]    gx_c;
  logic [FW-1:0] gy_c;
  logic          rot_cw, rot_ccw, blank_c;
  logic [AW-1:0] addr_c;
  logic [15:0]   ram [CELLS];
  logic [15:0]   cell_q;
  logic [2:0]    s1_gx_q, s2_gx_q;
  logic [FW-1:0] s1_gy_q;
  logic          s1_blank_q, s2_blank_q;
  logic [7:0]    s2_attr_q;
  logic [7+FW:0] font_addr_q;
  logic          glyph_bit;
  logic [2:0]    pix_q, pix_d;
  logic          pv_q, pv_d;
  logic          wr_ok, ack_q, err_q;
  assign hs_fall = hs_q & ~hs_i;
  assign vs_fall = vs_q & ~vs_i;
  assign blink_wrap = blink_q == BW'(BLINK_FRAMES-1);
  // line_ok stays low after reset so nothing is drawn until an hs edge re-aligns the counters
  always_comb begin
    cnt_x_d = hs_fall ? '0 : cnt_x_q + 12'(ce_pix);
    cnt_y_d = !hs_fall ? cnt_y_q : vs_i ? cnt_y_q + 12'd1 : '0;
    line_ok_d = line_ok_q | hs_fall;
    blink_d = !vs_fall ? blink_q : blink_wrap ? '0 : blink_q + BW'(1);
    phase_d = phase_q ^ (vs_fall & blink_wrap);
  end
  // bit 13 of the 14-bit sums is the sign; sx/sy only matter when both are non-negative
  assign x_c = {2'b00, cnt_x_q} + {{2{adj_x[11]}}, adj_x};
  assign y_c = {2'b00, cnt_y_q} + {{2{adj_y[11]}}, adj_y};
  assign sx = x_c[12:0] >> double_width;
  assign sy = y_c[12:0] >> double_height;
  assign rot_cw = rotate == 2'b01;
  assign rot_ccw = rotate == 2'b10;
  // FONT_H is a power of two, so "FONT_H-1 - v%FONT_H" and "7 - v%8" are bit inversions
  assign col_c = rot_cw ? 15'(sy >> 3) : rot_ccw ? 15'(COLS-1) - 15'(sy >> 3) : 15'(sx >> 3);
  assign row_c = rot_cw ? 15'(ROWS-1) - 15'(sx >> FW) : rot_ccw ? 15'(sx >> FW) : 15'(sy >> FW);
  assign gx_c = rot_cw ? sy[2:0] : rot_ccw ? ~sy[2:0] : sx[2:0];
  assign gy_c = rot_cw ? ~sx[FW-1:0] : rot_ccw ? sx[FW-1:0] : sy[FW-1:0];
  // a negative col/row wraps to a huge unsigned value and fails the range test
  assign blank_c = ~enable | ~line_ok_q | x_c[13] | y_c[13] | (col_c >= 15'(COLS)) | (row_c >= 15'(ROWS));
  assign addr_c = blank_c ? '0 : AW'(row_c * 15'(COLS) + col_c);
  assign wr_ok = wr.wr_en & ({1'b0, wr.wr_addr} < (AW+1)'(CELLS));
  assign glyph_bit = font_data[~s2_gx_q] & ~(s2_attr_q[6] & phase_q);
  always_comb begin
    pix_d = s2_blank_q ? '0 : glyph_bit ? s2_attr_q[2:0] : s2_attr_q[7] ? s2_attr_q[5:3] : '0;
    pv_d = ~s2_blank_q & (glyph_bit | s2_attr_q[7]);
  end
  always_ff @(posedge clk)
    if (wr_ok) ram[wr.wr_addr] <= wr.wr_data;
  // the RAM read register samples in the same edge as a write, so it sees the old cell
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      line_ok_q <= 1'b0;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      cell_q <= '0;
      s1_gx_q <= '0;
      s1_gy_q <= '0;
      s1_blank_q <= 1'b1;
      s2_gx_q <= '0;
      s2_attr_q <= '0;
      s2_blank_q <= 1'b1;
      font_addr_q <= '0;
      pix_q <= '0;
      pv_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      hs_q <= hs_i;
      vs_q <= vs_i;
      line_ok_q <= line_ok_d;
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      cell_q <= ram[addr_c];
      s1_gx_q <= gx_c;
      s1_gy_q <= gy_c;
      s1_blank_q <= blank_c;
      s2_gx_q <= s1_gx_q;
      s2_attr_q <= cell_q[15:8];
      s2_blank_q <= s1_blank_q;
      font_addr_q <= {cell_q[7:0], s1_gy_q};
      pix_q <= pix_d;
      pv_q <= pv_d;
      ack_q <= wr_ok;
      err_q <= wr.wr_en & ~wr_ok;
    end
  assign font_addr = font_addr_q;
  assign pixel_out = pix_q;
  assign pixel_valid = pv_q;
  assign wr.wr_ack = ack_q;
  assign wr.wr_err = err_q;
endmodule

// File: tb/tb_osd_text_overlay.sv
// tb_osd_text_overlay: directed stimulus, per-cycle check against a behavioural model plus literal checks
module tb_osd_text_overlay;
  localparam int COLS = 40, ROWS = 30, FH = 16, BF = 2, AW = 11, CELLS = COLS*ROWS;
  logic clk = 0, reset = 1, ce_pix = 1, hs_i = 1, vs_i = 1, enable = 0, dw = 0, dh = 0;
  logic [1:0] rotate = 0;
  logic [11:0] adj_x = 0, adj_y = 0;
  logic [11:0] font_addr;
  logic [7:0] font_data;
  logic [2:0] pixel_out;
  logic pixel_valid;
  int n_vec = 0, n_err = 0;
  osd_text_overlay_if #(.AW(AW)) wr();
  osd_text_overlay #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hs_i(hs_i), .vs_i(vs_i), .enable(enable),
    .double_width(dw), .double_height(dh), .rotate(rotate), .adj_x(adj_x), .adj_y(adj_y),
    .wr(wr), .font_addr(font_addr), .font_data(font_data),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid));
  always #5 clk = ~clk;
  // font ROM: char 0x41 has the leftmost bit set on every line, line 0 is exactly 0x80
  function automatic logic [7:0] font_fn(input logic [7:0] c, input int l);
    if (c == 8'h41) return l == 0 ? 8'h80 : 8'(8'h80 | (l*13));
    return 8'((c*29 + l*7) ^ 8'h3C);
  endfunction
  assign font_data = font_fn(font_addr[11:4], int'(font_addr[3:0]));
  typedef struct packed { logic blank; logic [7:0] ch; logic [7:0] attr; logic [2:0] gx; logic [3:0] gy; } ent_t;
  logic [15:0] mem [CELLS];
  ent_t p0, p1;
  int m_cx, m_cy, m_vse;
  logic m_ok, m_hs, m_vs, m_gb;
  logic [7:0] m_fb;
  logic [2:0] e_pix;
  logic e_pv, e_ack, e_err;
  function automatic ent_t entry_now();
    ent_t e;
    int x, y, sx, sy, col, row;
    e = '0;
    e.blank = 1;
    x = m_cx + int'($signed(adj_x));
    y = m_cy + int'($signed(adj_y));
    if (!enable || !m_ok || x < 0 || y < 0) return e;
    sx = dw ? x/2 : x;
    sy = dh ? y/2 : y;
    col = sx/8; e.gx = 3'(sx%8); row = sy/FH; e.gy = 4'(sy%FH);
    if (rotate == 1) begin
      col = sy/8; e.gx = 3'(sy%8); row = ROWS-1 - sx/FH; e.gy = 4'(FH-1 - sx%FH);
    end else if (rotate == 2) begin
      col = COLS-1 - sy/8; e.gx = 3'(7 - sy%8); row = sx/FH; e.gy = 4'(sx%FH);
    end
    if (col < 0 || col >= COLS || row < 0 || row >= ROWS) return e;
    e.blank = 0;
    {e.attr, e.ch} = mem[row*COLS + col];
    return e;
  endfunction
  // model: a cell fetched at one edge becomes the pixel two edges later, using the blink phase then
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cx = 0; m_cy = 0; m_vse = 0; m_ok = 0; m_hs = 0; m_vs = 0;
      p0 = '0; p0.blank = 1; p1 = p0;
      e_pix = 0; e_pv = 0; e_ack = 0; e_err = 0;
    end else begin
      m_fb = font_fn(p1.ch, int'(p1.gy));
      m_gb = m_fb[7 - p1.gx] && !(p1.attr[6] && (m_vse/BF)%2 == 1);
      e_pv = !p1.blank && (m_gb || p1.attr[7]);
      e_pix = p1.blank ? 3'd0 : m_gb ? p1.attr[2:0] : p1.attr[7] ? p1.attr[5:3] : 3'd0;
      p1 = p0;
      p0 = entry_now();
      if (m_hs && !hs_i) begin
        m_cx = 0; m_cy = vs_i ? m_cy + 1 : 0; m_ok = 1;
      end else if (ce_pix) m_cx++;
      if (m_vs && !vs_i) m_vse++;
      m_hs = hs_i; m_vs = vs_i;
      e_ack = wr.wr_en && int'(wr.wr_addr) < CELLS;
      e_err = wr.wr_en && !(int'(wr.wr_addr) < CELLS);
      if (e_ack) mem[wr.wr_addr] = wr.wr_data;
    end
  end
  always @(negedge clk) if (!reset) begin
    n_vec++;
    if ({pixel_out, pixel_valid, wr.wr_ack, wr.wr_err} !== {e_pix, e_pv, e_ack, e_err}) begin
      n_err++;
      $display("FAIL model t=%0t pix/valid/ack/err got %0d/%b/%b/%b want %0d/%b/%b/%b",
               $time, pixel_out, pixel_valid, wr.wr_ack, wr.wr_err, e_pix, e_pv, e_ack, e_err);
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr_cell(input int a, input logic [15:0] d);
    wr.wr_en = 1; wr.wr_addr = AW'(a); wr.wr_data = d;
    tick();
    wr.wr_en = 0;
  endtask
  // hs falls at a negedge; returns one negedge after the counters were re-aligned (x=0)
  task automatic hs_edge(input logic frame);
    vs_i = !frame; hs_i = 0;
    tick();
    hs_i = 1; vs_i = 1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    wr.wr_en = 0; wr.wr_addr = 0; wr.wr_data = 0;
    tick(3);
    chk("rst_pix", 32'(pixel_out), 0);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_ack_err", 32'({wr.wr_ack, wr.wr_err}), 0);
    chk("rst_font_addr", 32'(font_addr), 0);
    reset = 0;
    for (int i = 0; i < CELLS; i++) wr_cell(i, 16'((i*16'h2B1D) ^ 16'h1234));
    wr_cell(0, 16'h0741);
    chk("wr_ack0", 32'({wr.wr_ack, wr.wr_err}), 32'b10);
    enable = 1;
    hs_edge(1); tick(3);
    chk("fg_px0", 32'({pixel_valid, pixel_out}), 32'hF);
    tick();
    chk("fg_px1", 32'({pixel_valid, pixel_out}), 32'h0);
    tick(340);
    wr_cell(0, 16'h8741);
    hs_edge(1); tick(4);
    chk("opaque_bg0", 32'({pixel_valid, pixel_out}), 32'h8);
    tick(340);
    wr_cell(0, 16'h8F41);
    hs_edge(1); tick(4);
    chk("opaque_bg1", 32'({pixel_valid, pixel_out}), 32'h9);
    tick(340);
    wr_cell(1200, 16'hFFFF);
    chk("wr_err_1200", 32'({wr.wr_ack, wr.wr_err}), 32'b01);
    wr_cell(1199, 16'h0123);
    chk("wr_ack_1199", 32'({wr.wr_ack, wr.wr_err}), 32'b10);
    wr_cell(0, 16'h0741);
    dw = 1;
    hs_edge(1); tick(3);
    chk("dw_x0", 32'({pixel_valid, pixel_out}), 32'hF);
    tick();
    chk("dw_x1", 32'({pixel_valid, pixel_out}), 32'hF);
    tick();
    chk("dw_x2", 32'({pixel_valid, pixel_out}), 32'h0);
    tick(640);
    dw = 0; adj_x = -12'sd4;
    hs_edge(1); tick(2);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("adjx_blank", 32'(pixel_valid), 0);
    end
    tick();
    chk("adjx_px4", 32'({pixel_valid, pixel_out}), 32'hF);
    tick(340);
    adj_x = 0;
    wr_cell(1160, 16'h0741);
    rotate = 2'b01;
    hs_edge(1); tick(2);
    chk("rot_font_addr", 32'(font_addr), 32'h41F);
    for (int k = 0; k < FH; k++) begin
      tick();
      chk("rot_px", 32'({pixel_valid, pixel_out}), 32'hF);
    end
    tick(300);
    for (int l = 0; l < 3; l++) begin hs_edge(0); tick(500); end
    rotate = 2'b10;
    for (int l = 0; l < 3; l++) begin hs_edge(l == 0); tick(500); end
    rotate = 2'b00; dh = 1; adj_y = -12'sd2; adj_x = 12'sd5;
    for (int l = 0; l < 4; l++) begin hs_edge(l == 0); tick(340); end
    dh = 0; adj_y = 0; adj_x = 0;
    reset = 1; tick(); reset = 0;
    wr_cell(0, 16'h4741);
    hs_edge(0); tick(3);
    chk("blink_f0", 32'({pixel_valid, pixel_out}), 32'hF);
    tick(340);
    hs_edge(1); tick(3);
    chk("blink_f1", 32'({pixel_valid, pixel_out}), 32'hF);
    tick(340);
    hs_edge(1); tick(3);
    chk("blink_f2", 32'({pixel_valid, pixel_out}), 32'h0);
    tick(340);
    hs_edge(1); tick(3);
    chk("blink_f3", 32'({pixel_valid, pixel_out}), 32'h0);
    tick(340);
    hs_edge(1); tick(3);
    wr.wr_en = 1; wr.wr_addr = 5; wr.wr_data = 16'h0741;
    #2 reset = 1;
    #1;
    chk("midrst_out", 32'({pixel_out, pixel_valid, wr.wr_ack, wr.wr_err}), 0);
    chk("midrst_font_addr", 32'(font_addr), 0);
    @(negedge clk);
    wr.wr_en = 0; reset = 0;
    tick(6);
    chk("midrst_blank", 32'(pixel_valid), 0);
    hs_edge(1); tick(3);
    chk("midrst_resync", 32'({pixel_valid, pixel_out}), 32'hF);
    tick(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
